maze_mem_arbiter: RTL and testbench

//   Shares the single-port maze memory (one bit per cell, addressed by X/Y) between two requesters:
//   - the rat solver datapath (port r_*);
//   - the host maze loader/debug port (port h_*).

---
 rtl/maze_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_maze_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/maze_mem_arbiter.sv
// Two-requester (rat solver / host loader) arbiter for the single-port maze RAM.
// Define ARB_HOST_PRIORITY_EN for fixed host priority; otherwise round-robin.
module maze_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 1,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_req,
  input  logic              r_wr,
  input  logic [ADDR_W-1:0] r_x,
  input  logic [ADDR_W-1:0] r_y,
  input  logic [DATA_W-1:0] r_wdata,
  output logic              r_ack,
  output logic [DATA_W-1:0] r_rdata,
  input  logic              h_req,
  input  logic              h_wr,
  input  logic [ADDR_W-1:0] h_x,
  input  logic [ADDR_W-1:0] h_y,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] mem_x,
  output logic [ADDR_W-1:0] mem_y,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               owner_r, owner_s;  // 1 = host
  logic               wr_r, wr_s;
  logic [ADDR_W-1:0]  x_r, x_s, y_r, y_s;
  logic [DATA_W-1:0]  wdata_r, wdata_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               capture_s;
  logic               pick_host_s;

`ifdef ARB_HOST_PRIORITY_EN
  assign pick_host_s = h_req;
`else
  logic last_grant_r;  // 1 = host

  // Remember the last served requester so a conflict goes to the other one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= 1'b1;
    end else if (state_r == ACK) begin
      last_grant_r <= owner_r;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign pick_host_s = h_req & (~r_req | ~last_grant_r);
`endif

  // Next-state logic; request inputs are only looked at while idle
  always_comb begin
    state_s   = state_r;
    owner_s   = owner_r;
    wr_s      = wr_r;
    x_s       = x_r;
    y_s       = y_r;
    wdata_s   = wdata_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (r_req || h_req) begin
          state_s = ISSUE;
          owner_s = pick_host_s;
          wr_s    = pick_host_s ? h_wr    : r_wr;
          x_s     = pick_host_s ? h_x     : r_x;
          y_s     = pick_host_s ? h_y     : r_y;
          wdata_s = pick_host_s ? h_wdata : r_wdata;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (wr_r) begin
          state_s = ACK;
        end else begin
          state_s = WAIT;
          cnt_s   = CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s   = ACK;
          capture_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched transaction and outputs, all registered from next-state values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      owner_r <= 1'b0;
      wr_r    <= 1'b0;
      x_r     <= {ADDR_W{1'b0}};
      y_r     <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      r_ack   <= 1'b0;
      h_ack   <= 1'b0;
      r_rdata <= {DATA_W{1'b0}};
      h_rdata <= {DATA_W{1'b0}};
      mem_x   <= {ADDR_W{1'b0}};
      mem_y   <= {ADDR_W{1'b0}};
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      mem_din <= {DATA_W{1'b0}};
      grant   <= 2'b00;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      wr_r    <= wr_s;
      x_r     <= x_s;
      y_r     <= y_s;
      wdata_r <= wdata_s;
      cnt_r   <= cnt_s;
      r_ack   <= (state_s == ACK) && !owner_s;
      h_ack   <= (state_s == ACK) && owner_s;
      if (capture_s && !owner_r) r_rdata <= mem_dout;
      if (capture_s && owner_r)  h_rdata <= mem_dout;
      mem_x   <= (state_s == IDLE) ? {ADDR_W{1'b0}} : x_s;
      mem_y   <= (state_s == IDLE) ? {ADDR_W{1'b0}} : y_s;
      mem_din <= (state_s == IDLE) ? {DATA_W{1'b0}} : wdata_s;
      mem_rd  <= (state_s == ISSUE) && !wr_s;
      mem_wr  <= (state_s == ISSUE) && wr_s;
      grant   <= (state_s == IDLE) ? 2'b00 : (owner_s ? 2'b10 : 2'b01);
      busy    <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Scoreboard bench for maze_mem_arbiter with a RAM model of read latency 2.
module tb_maze_mem_arbiter;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b1;
  logic       r_req = 1'b0, r_wr = 1'b0, r_wdata = 1'b0;
  logic [3:0] r_x = 4'd0, r_y = 4'd0;
  logic       h_req = 1'b0, h_wr = 1'b0, h_wdata = 1'b0;
  logic [3:0] h_x = 4'd0, h_y = 4'd0;
  logic       r_ack, r_rdata, h_ack, h_rdata;
  logic [3:0] mem_x, mem_y;
  logic       mem_rd, mem_wr, mem_din, mem_dout, busy;
  logic [1:0] grant;

  always #5 clk = ~clk;

  maze_mem_arbiter #(.ADDR_W(4), .DATA_W(1), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .r_req(r_req), .r_wr(r_wr), .r_x(r_x), .r_y(r_y), .r_wdata(r_wdata),
    .r_ack(r_ack), .r_rdata(r_rdata),
    .h_req(h_req), .h_wr(h_wr), .h_x(h_x), .h_y(h_y), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata),
    .mem_x(mem_x), .mem_y(mem_y), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_dout(mem_dout), .grant(grant), .busy(busy)
  );

  // RAM model: data valid exactly RL cycles after the mem_rd cycle
  logic       ram [0:255];
  logic [1:0] pv, pd;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 1'b0;
    end else if (mem_wr) begin
      ram[{mem_x, mem_y}] <= mem_din;
    end
    pv[0] <= mem_rd;
    pd[0] <= ram[{mem_x, mem_y}];
    pv[1] <= pv[0];
    pd[1] <= pd[0];
  end
  assign mem_dout = pv[1] ? pd[1] : 1'b0;

  typedef struct { logic host; logic wr; logic data; } exp_t;
  exp_t sb[$];
  logic model [0:255];
  int checks = 0, errors = 0;
  int ack_seen = 0, rd_pulses = 0, wr_pulses = 0, exp_rd = 0, exp_wr = 0;
  logic exp_rr = 1'b0, exp_hr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ack monitor: pops the scoreboard and checks owner and both rdata ports
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      exp_rr = 1'b0;
      exp_hr = 1'b0;
    end else begin
      if (mem_rd) rd_pulses++;
      if (mem_wr) wr_pulses++;
      if (r_ack || h_ack) begin
        exp_t e;
        ack_seen++;
        check_eq("ack_both", 32'(r_ack & h_ack), 32'(1'b0));
        check_eq("sb_nonempty_on_ack", 32'(sb.size() != 0), 32'(1'b1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("ack_owner", 32'(h_ack), 32'(e.host));
          if (!e.wr) begin
            if (e.host) exp_hr = e.data;
            else        exp_rr = e.data;
          end
          check_eq("r_rdata", 32'(r_rdata), 32'(exp_rr));
          check_eq("h_rdata", 32'(h_rdata), 32'(exp_hr));
        end
      end
    end
  end

  task automatic drive(input logic host, input logic req, input logic wr,
                       input logic [3:0] x, input logic [3:0] y, input logic wd);
    if (host) begin
      h_req = req; h_wr = wr; h_x = x; h_y = y; h_wdata = wd;
    end else begin
      r_req = req; r_wr = wr; r_x = x; r_y = y; r_wdata = wd;
    end
  endtask

  task automatic push(input logic host, input logic wr,
                      input logic [3:0] x, input logic [3:0] y, input logic wd);
    exp_t e;
    e.host = host;
    e.wr   = wr;
    e.data = wr ? 1'b0 : model[{x, y}];
    sb.push_back(e);
    if (wr) begin
      model[{x, y}] = wd;
      exp_wr++;
    end else begin
      exp_rd++;
    end
  endtask

  task automatic single(input logic host, input logic wr,
                        input logic [3:0] x, input logic [3:0] y, input logic wd);
    int n;
    bit got;
    @(negedge clk);
    drive(host, 1'b1, wr, x, y, wd);
    push(host, wr, x, y, wd);
    @(negedge clk);
    check_eq("issue_strobe", 32'({mem_rd, mem_wr}), wr ? 32'(2'b01) : 32'(2'b10));
    check_eq("issue_addr", 32'({mem_x, mem_y}), 32'({x, y}));
    check_eq("issue_grant", 32'(grant), host ? 32'(2'b10) : 32'(2'b01));
    if (wr) check_eq("issue_din", 32'(mem_din), 32'(wd));
    n = 1;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (r_ack || h_ack) got = 1'b1;
    end
    check_eq("ack_latency", 32'(n), wr ? 32'(2) : 32'(2 + RL));
    drive(host, 1'b0, wr, x, y, wd);
  endtask

  initial begin
    int base, k, cnt;
    for (int i = 0; i < 256; i++) model[i] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("reset_outs", 32'({r_ack, r_rdata, h_ack, h_rdata, mem_x, mem_y, mem_rd,
                                mem_wr, mem_din, grant, busy}), 32'(0));
    rst = 1'b1;
    clr = 1'b0;

    // Reset while a host read sits in WAIT: dropped, never acked
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 4'd15, 4'd15, 1'b0);
    exp_rd++;
    repeat (2) @(negedge clk);
    check_eq("midread_wait", 32'({busy, mem_rd, grant}), 32'({1'b1, 1'b0, 2'b10}));
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    check_eq("midreset_outs", 32'({r_ack, r_rdata, h_ack, h_rdata, mem_x, mem_y, mem_rd,
                                   mem_wr, mem_din, grant, busy}), 32'(0));
    rst = 1'b1;
    base = ack_seen;
    repeat (8) @(negedge clk);
    check_eq("dropped_no_ack", 32'(ack_seen - base), 32'(0));

    // Single-requester writes and reads
    single(1'b0, 1'b1, 4'd3, 4'd5, 1'b1);
    single(1'b1, 1'b1, 4'd15, 4'd15, 1'b1);
    single(1'b1, 1'b0, 4'd15, 4'd15, 1'b0);
    single(1'b0, 1'b0, 4'd3, 4'd5, 1'b0);
    single(1'b1, 1'b1, 4'd0, 4'd7, 1'b1);

    // Simultaneous requests held across acks
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 4'd5, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0);
`ifdef ARB_HOST_PRIORITY_EN
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 4'd1, 4'd1, 1'b0);
`else
    for (int i = 0; i < 4; i++) push(i[0], 1'b0, i[0] ? 4'd1 : 4'd3, i[0] ? 4'd1 : 4'd5, 1'b0);
`endif
    k = 0;
    cnt = 0;
    while (k < 4 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (r_ack || h_ack) k++;
    end
    check_eq("four_acks", 32'(k), 32'(4));
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

    // Host arrives while a rat read is in flight
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 4'd5, 1'b0);
    push(1'b0, 1'b0, 4'd3, 4'd5, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 1'b1);
    push(1'b1, 1'b1, 4'd2, 4'd2, 1'b1);
    check_eq("t5_rat_issue", 32'({grant, mem_rd}), 32'({2'b01, 1'b1}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t5_hold", 32'({grant, mem_wr}), 32'({2'b01, 1'b0}));
    end
    check_eq("t5_rat_ack", 32'(r_ack), 32'(1'b1));
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    check_eq("t5_idle", 32'({grant, busy}), 32'(0));
    @(negedge clk);
    check_eq("t5_host_issue", 32'({grant, mem_wr, mem_x, mem_y}),
             32'({2'b10, 1'b1, 4'd2, 4'd2}));
    cnt = 0;
    while (!h_ack && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("t5_host_ack", 32'(h_ack), 32'(1'b1));
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

    // Address change and early req drop during WAIT are ignored
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 1'b0);
    push(1'b0, 1'b0, 4'd0, 4'd7, 1'b0);
    repeat (2) @(negedge clk);
    r_x = 4'd9;
    check_eq("t6_mem_x_wait1", 32'(mem_x), 32'(0));
    @(negedge clk);
    r_req = 1'b0;
    check_eq("t6_mem_x_wait2", 32'(mem_x), 32'(0));
    @(negedge clk);
    check_eq("t6_ack", 32'({r_ack, r_rdata}), 32'({1'b1, 1'b1}));

    repeat (4) @(negedge clk);
    check_eq("sb_empty", 32'(sb.size()), 32'(0));
    check_eq("rd_pulses", 32'(rd_pulses), 32'(exp_rd));
    check_eq("wr_pulses", 32'(wr_pulses), 32'(exp_wr));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
